// File: rtl/cim_cmd_dispatcher.sv
// In-order command front-end for MUL_controller: buffers host load/store and compute
// commands and issues them on ExLdSt (single cycle) and Compute (valid/ready).
module cim_cmd_dispatcher #(
  parameter int ROW_NUM = 16,
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 8,
  localparam int CMD_W  = 7 + 3 * ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               host_type,
  input  logic [CMD_W-1:0]   host_cmd,
  input  logic [ROW_NUM-1:0] host_wdata,
  output logic               rd_valid,
  output logic [ROW_NUM-1:0] rd_data,
  output logic               ExLdSt_valid,
  output logic [ADDR_W:0]    ExLdSt_command,
  output logic [ROW_NUM-1:0] ExLdSt_wdata,
  input  logic [ROW_NUM-1:0] ExLdSt_rdata,
  output logic               Compute_valid,
  input  logic               Compute_ready,
  output logic [CMD_W-1:0]   Compute_command,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 1 + CMD_W + ROW_NUM;

  typedef enum logic {C_IDLE, C_WAIT} comp_state_e;
  comp_state_e state_q, state_d;

  logic [ENT_W-1:0]   fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CMD_W-1:0]   comp_cmd_q;
  logic               ldst_valid_q;
  logic [ADDR_W:0]    ldst_cmd_q;
  logic [ROW_NUM-1:0] ldst_wdata_q;
  logic               rd_pend_q, rd_valid_q;
  logic [ROW_NUM-1:0] rd_data_q;

  logic               full, push, pop, head_valid, head_type;
  logic               wait_after, ldst_issue, comp_issue;
  logic [CMD_W-1:0]   head_cmd;
  logic [ROW_NUM-1:0] head_wdata;
  logic [2:0]         clash_vec;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign push       = host_valid & ~full;
  assign head_valid = (count_q != '0);
  assign {head_type, head_cmd, head_wdata} = fifo_mem[rd_ptr_q];

  // Clash and stall decisions use the post-retire view of the compute slot.
  assign wait_after = (state_q == C_WAIT) & ~Compute_ready;

  for (genvar gi = 0; gi < 3; gi++) begin : g_clash
    assign clash_vec[gi] = (comp_cmd_q[gi*ADDR_W +: ADDR_W] == head_cmd[ADDR_W-1:0]);
  end

  assign ldst_issue = head_valid & ~head_type & ~(wait_after & (|clash_vec));
  assign comp_issue = head_valid & head_type & ~wait_after;
  assign pop        = ldst_issue | comp_issue;

  always_comb begin
    state_d       = state_q;
    Compute_valid = (state_q == C_WAIT);
    case (state_q)
      C_IDLE:  if (comp_issue) state_d = C_WAIT;
      C_WAIT:  if (Compute_ready) state_d = comp_issue ? C_WAIT : C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {host_type, host_cmd, host_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      comp_cmd_q   <= '0;
      ldst_valid_q <= 1'b0;
      ldst_cmd_q   <= '0;
      ldst_wdata_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ldst_valid_q <= ldst_issue;
      if (push)       wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      if (pop)        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
      if (comp_issue) comp_cmd_q <= head_cmd;
      if (ldst_issue) begin
        ldst_cmd_q   <= head_cmd[ADDR_W:0];
        ldst_wdata_q <= head_wdata;
      end
      // Store read-back: controller data is valid the cycle after the issue strobe.
      rd_pend_q  <= ldst_valid_q & ~ldst_cmd_q[ADDR_W];
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= ExLdSt_rdata;
    end
  end

  assign host_ready      = ~full;
  assign fifo_count      = count_q;
  assign Compute_command = comp_cmd_q;
  assign ExLdSt_valid    = ldst_valid_q;
  assign ExLdSt_command  = ldst_cmd_q;
  assign ExLdSt_wdata    = ldst_wdata_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign busy            = head_valid | Compute_valid | (ldst_valid_q & ~ldst_cmd_q[ADDR_W]) | rd_pend_q;

endmodule

// File: tb/tb_cim_cmd_dispatcher.sv
// Bench for cim_cmd_dispatcher: directed scenarios plus random traffic scored against
// an in-order command queue, a row-array model and an operand-clash rule check.
module tb_cim_cmd_dispatcher;
  localparam int ROW_NUM = 16;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 8;
  localparam int CMD_W   = 7 + 3 * ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               host_valid, host_ready, host_type;
  logic [CMD_W-1:0]   host_cmd;
  logic [ROW_NUM-1:0] host_wdata;
  logic               rd_valid;
  logic [ROW_NUM-1:0] rd_data;
  logic               ExLdSt_valid;
  logic [ADDR_W:0]    ExLdSt_command;
  logic [ROW_NUM-1:0] ExLdSt_wdata, ExLdSt_rdata;
  logic               Compute_valid, Compute_ready;
  logic [CMD_W-1:0]   Compute_command;
  logic [CNT_W-1:0]   fifo_count;
  logic               busy;

  always #5 clk = ~clk;

  cim_cmd_dispatcher #(.ROW_NUM(ROW_NUM), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_type(host_type),
    .host_cmd(host_cmd), .host_wdata(host_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ExLdSt_valid(ExLdSt_valid), .ExLdSt_command(ExLdSt_command),
    .ExLdSt_wdata(ExLdSt_wdata), .ExLdSt_rdata(ExLdSt_rdata),
    .Compute_valid(Compute_valid), .Compute_ready(Compute_ready),
    .Compute_command(Compute_command), .fifo_count(fifo_count), .busy(busy)
  );

  typedef struct { bit ctype; logic [CMD_W-1:0] cmd; logic [ROW_NUM-1:0] wdata; } ent_t;
  typedef struct { int due; logic [ROW_NUM-1:0] data; } rd_t;

  ent_t               model_q[$];
  rd_t                exp_rd[$];
  logic [ROW_NUM-1:0] arr [2**ADDR_W];
  int checks = 0, failures = 0, cyc = 0;
  int n_ldst = 0, n_comp = 0, last_ld_cyc = 0, last_st_cyc = 0, last_rd_cyc = 0;
  logic [ROW_NUM-1:0] last_rd_data = '0;
  bit                 st_pend = 0;
  logic [ADDR_W-1:0]  st_pend_addr = '0;

  function automatic logic [CMD_W-1:0] mk_ls(input bit wr, input logic [ADDR_W-1:0] a);
    return {{(CMD_W-ADDR_W-1){1'b0}}, wr, a};
  endfunction

  function automatic logic [CMD_W-1:0] mk_comp(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                                               input logic [ADDR_W-1:0] d);
    return {1'b0, 3'b111, 3'b010, s1, s2, d};
  endfunction

  // Scores one cycle: issue order, clash rule, read-back timing/data, occupancy, busy.
  task automatic monitor(input bit cv0, input bit cr0, input logic [CMD_W-1:0] cmd0);
    ent_t e;
    rd_t r;
    logic [ADDR_W-1:0] a;
    bit exp_busy;
    if (!rst_n) begin
      model_q.delete();
      exp_rd.delete();
      st_pend = 0;
      for (int i = 0; i < 2**ADDR_W; i++) arr[i] = '0;
      return;
    end
    if (st_pend) ExLdSt_rdata = arr[st_pend_addr];
    else         ExLdSt_rdata = ROW_NUM'($urandom);
    st_pend = 0;

    if (ExLdSt_valid) begin
      a = ExLdSt_command[ADDR_W-1:0];
      $display("[%0d] ldst wr=%0b addr=%0d wdata=%h", cyc, ExLdSt_command[ADDR_W], a, ExLdSt_wdata);
      checks++;
      if (model_q.size() == 0) begin
        failures++;
        $display("FAIL ldst_order: issued cmd=%h, required nothing pending", ExLdSt_command);
      end else begin
        e = model_q.pop_front();
        if (e.ctype !== 1'b0 || ExLdSt_command !== e.cmd[ADDR_W:0] ||
            (e.cmd[ADDR_W] && ExLdSt_wdata !== e.wdata)) begin
          failures++;
          $display("FAIL ldst_order: got cmd=%h wdata=%h, required type=%0b cmd=%h wdata=%h",
                   ExLdSt_command, ExLdSt_wdata, e.ctype, e.cmd[ADDR_W:0], e.wdata);
        end
      end
      checks++;
      if (cv0 && !cr0 && (a == cmd0[ADDR_W-1:0] || a == cmd0[2*ADDR_W-1:ADDR_W] ||
                          a == cmd0[3*ADDR_W-1:2*ADDR_W])) begin
        failures++;
        $display("FAIL ldst_clash: addr=%0d issued while compute %h pending, required stall", a, cmd0);
      end
      n_ldst++;
      if (ExLdSt_command[ADDR_W]) begin
        arr[a] = ExLdSt_wdata;
        last_ld_cyc = cyc;
      end else begin
        exp_rd.push_back('{cyc + 2, arr[a]});
        st_pend = 1;
        st_pend_addr = a;
        last_st_cyc = cyc;
      end
    end

    if (cv0 && !cr0) begin
      checks++;
      if (Compute_valid !== 1'b1 || Compute_command !== cmd0) begin
        failures++;
        $display("FAIL comp_hold: valid=%0b cmd=%h, required valid=1 cmd=%h", Compute_valid, Compute_command, cmd0);
      end
    end else if (Compute_valid) begin
      $display("[%0d] compute cmd=%h", cyc, Compute_command);
      checks++;
      if (model_q.size() == 0) begin
        failures++;
        $display("FAIL comp_order: issued cmd=%h, required nothing pending", Compute_command);
      end else begin
        e = model_q.pop_front();
        if (e.ctype !== 1'b1 || Compute_command !== e.cmd) begin
          failures++;
          $display("FAIL comp_order: got cmd=%h, required type=%0b cmd=%h", Compute_command, e.ctype, e.cmd);
        end
      end
      n_comp++;
    end

    if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
      r = exp_rd.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== r.data) begin
        failures++;
        $display("FAIL readback: rd_valid=%0b rd_data=%h, required 1 %h", rd_valid, rd_data, r.data);
      end
      $display("[%0d] readback data=%h", cyc, rd_data);
      last_rd_cyc = cyc;
      last_rd_data = rd_data;
    end else if (rd_valid) begin
      checks++;
      failures++;
      $display("FAIL readback_spurious: rd_valid=1 data=%h, required rd_valid=0", rd_data);
    end

    checks++;
    if (fifo_count !== CNT_W'(model_q.size()) || host_ready !== (model_q.size() < DEPTH)) begin
      failures++;
      $display("FAIL occupancy: count=%0d ready=%0b, required count=%0d ready=%0b",
               fifo_count, host_ready, model_q.size(), model_q.size() < DEPTH);
    end
    exp_busy = (model_q.size() != 0) || Compute_valid || (exp_rd.size() != 0);
    checks++;
    if (busy !== exp_busy) begin
      failures++;
      $display("FAIL busy: got %0b, required %0b", busy, exp_busy);
    end
  endtask

  task automatic tick();
    bit pushed, cv0, cr0;
    logic [CMD_W-1:0] cmd0;
    ent_t e;
    pushed  = host_valid && host_ready && rst_n;
    e.ctype = host_type;
    e.cmd   = host_cmd;
    e.wdata = host_wdata;
    cv0 = Compute_valid;
    cr0 = Compute_ready;
    cmd0 = Compute_command;
    @(posedge clk);
    #1;
    cyc++;
    if (pushed) model_q.push_back(e);
    monitor(cv0, cr0, cmd0);
  endtask

  task automatic push(input bit t, input logic [CMD_W-1:0] c, input logic [ROW_NUM-1:0] d);
    int n = 0;
    host_valid = 1'b1;
    host_type  = t;
    host_cmd   = c;
    host_wdata = d;
    while (!host_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!host_ready) begin
      failures++;
      $display("FAIL push_timeout: host_ready=0 after %0d cycles, required 1", n);
    end
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_cv();
    int n = 0;
    while (!Compute_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (Compute_valid !== 1'b1) begin
      failures++;
      $display("FAIL compute_issue_timeout: Compute_valid=%0b, required 1", Compute_valid);
    end
  endtask

  task automatic test_reset();
    host_valid = 0; host_type = 0; host_cmd = '0; host_wdata = '0;
    Compute_ready = 0; ExLdSt_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (host_ready !== 1'b1 || fifo_count !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: ready=%0b count=%0d busy=%0b, required 1 0 0", host_ready, fifo_count, busy);
    end
    checks++;
    if (ExLdSt_valid !== 1'b0 || Compute_valid !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids: ldst=%0b comp=%0b rd=%0b, required 0 0 0", ExLdSt_valid, Compute_valid, rd_valid);
    end
    checks++;
    if (ExLdSt_command !== '0 || ExLdSt_wdata !== '0 || Compute_command !== '0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_data: ldcmd=%h wdata=%h ccmd=%h rdata=%h, required all 0",
               ExLdSt_command, ExLdSt_wdata, Compute_command, rd_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_store();
    int n0 = n_ldst;
    push(1'b0, mk_ls(1'b1, 6'd1), 16'haa55);
    push(1'b0, mk_ls(1'b0, 6'd1), 16'h0000);
    repeat (6) tick();
    checks++;
    if (n_ldst - n0 != 2 || last_st_cyc != last_ld_cyc + 1) begin
      failures++;
      $display("FAIL t1_issue: issues=%0d st_cyc=%0d, required 2 and ld_cyc+1=%0d", n_ldst - n0, last_st_cyc, last_ld_cyc + 1);
    end
    checks++;
    if (last_rd_data !== 16'haa55 || last_rd_cyc != last_st_cyc + 2) begin
      failures++;
      $display("FAIL t1_readback: data=%h cyc=%0d, required aa55 at %0d", last_rd_data, last_rd_cyc, last_st_cyc + 2);
    end
  endtask

  task automatic test_clash_stall();
    int n0, r;
    logic [CMD_W-1:0] mul_cmd;
    mul_cmd = 25'b0_111_010_000001_000010_000101;
    Compute_ready = 0;
    push(1'b0, mk_ls(1'b1, 6'd1), 16'd55);
    push(1'b0, mk_ls(1'b1, 6'd2), 16'd110);
    push(1'b1, mk_comp(6'd1, 6'd2, 6'd5), '0);
    wait_cv();
    checks++;
    if (Compute_command !== mul_cmd) begin
      failures++;
      $display("FAIL t2_cmd: got %h, required %h", Compute_command, mul_cmd);
    end
    n0 = n_ldst;
    push(1'b0, mk_ls(1'b0, 6'd5), '0);
    repeat (10) tick();
    checks++;
    if (n_ldst != n0 || Compute_valid !== 1'b1) begin
      failures++;
      $display("FAIL t2_held: issues=%0d valid=%0b, required 0 1", n_ldst - n0, Compute_valid);
    end
    r = cyc;
    Compute_ready = 1;
    tick();
    Compute_ready = 0;
    checks++;
    if (Compute_valid !== 1'b0 || n_ldst != n0 + 1 || last_st_cyc != r + 1) begin
      failures++;
      $display("FAIL t2_release: valid=%0b issues=%0d st_cyc=%0d, required 0 1 %0d", Compute_valid, n_ldst - n0, last_st_cyc, r + 1);
    end
    repeat (3) tick();
  endtask

  task automatic test_no_clash();
    Compute_ready = 0;
    push(1'b1, mk_comp(6'd1, 6'd2, 6'd3), '0);
    wait_cv();
    push(1'b0, mk_ls(1'b1, 6'd7), 16'h1234);
    tick();
    checks++;
    if (ExLdSt_valid !== 1'b1 || ExLdSt_command !== 7'b1_000111 || Compute_valid !== 1'b1) begin
      failures++;
      $display("FAIL t3_overlap: ldst=%0b cmd=%h comp=%0b, required 1 47 1", ExLdSt_valid, ExLdSt_command, Compute_valid);
    end
    Compute_ready = 1;
    tick();
    Compute_ready = 0;
    tick();
  endtask

  task automatic test_fifo_full();
    int n0, acc = 0, k = 0;
    bit ok;
    Compute_ready = 0;
    push(1'b1, mk_comp(6'd9, 6'd10, 6'd11), '0);
    wait_cv();
    n0 = n_ldst;
    host_valid = 1'b1;
    host_type  = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      host_cmd   = mk_ls(1'b1, (acc == 0) ? 6'd9 : ADDR_W'(20 + acc));
      host_wdata = ROW_NUM'(16'h4000 + acc);
      ok = host_ready;
      tick();
      if (ok) acc++;
    end
    checks++;
    if (acc != DEPTH || fifo_count !== CNT_W'(DEPTH) || host_ready !== 1'b0 || n_ldst != n0) begin
      failures++;
      $display("FAIL t4_full: accepted=%0d count=%0d ready=%0b issues=%0d, required %0d %0d 0 0",
               acc, fifo_count, host_ready, n_ldst - n0, DEPTH, DEPTH);
    end
    Compute_ready = 1;
    while (acc < DEPTH + 2 && k < 50) begin
      host_cmd   = mk_ls(1'b1, ADDR_W'(20 + acc));
      host_wdata = ROW_NUM'(16'h4000 + acc);
      ok = host_ready;
      tick();
      Compute_ready = 0;
      if (ok) acc++;
      k++;
    end
    host_valid = 1'b0;
    k = 0;
    while ((fifo_count != 0 || busy) && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (n_ldst != n0 + DEPTH + 2) begin
      failures++;
      $display("FAIL t4_drain: issues=%0d, required %0d", n_ldst - n0, DEPTH + 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [CMD_W-1:0] c1, c2;
    c1 = mk_comp(6'd12, 6'd13, 6'd14);
    c2 = mk_comp(6'd15, 6'd16, 6'd17);
    Compute_ready = 1;
    push(1'b1, c1, '0);
    push(1'b1, c2, '0);
    checks++;
    if (Compute_valid !== 1'b1 || Compute_command !== c1) begin
      failures++;
      $display("FAIL t5_first: valid=%0b cmd=%h, required 1 %h", Compute_valid, Compute_command, c1);
    end
    tick();
    checks++;
    if (Compute_valid !== 1'b1 || Compute_command !== c2) begin
      failures++;
      $display("FAIL t5_second: valid=%0b cmd=%h, required 1 %h", Compute_valid, Compute_command, c2);
    end
    tick();
    checks++;
    if (Compute_valid !== 1'b0) begin
      failures++;
      $display("FAIL t5_end: valid=%0b, required 0", Compute_valid);
    end
    Compute_ready = 0;
  endtask

  task automatic test_async_reset();
    int n0;
    Compute_ready = 0;
    push(1'b1, mk_comp(6'd30, 6'd31, 6'd32), '0);
    wait_cv();
    for (int i = 0; i < 3; i++) push(1'b0, mk_ls(1'b1, 6'd30), ROW_NUM'(i));
    tick();
    checks++;
    if (fifo_count !== CNT_W'(3) || Compute_valid !== 1'b1) begin
      failures++;
      $display("FAIL t6_setup: count=%0d valid=%0b, required 3 1", fifo_count, Compute_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Compute_valid !== 1'b0 || fifo_count !== '0 || host_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t6_async: valid=%0b count=%0d ready=%0b busy=%0b, required 0 0 1 0",
               Compute_valid, fifo_count, host_ready, busy);
    end
    n0 = n_ldst;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (n_ldst != n0 || Compute_valid !== 1'b0) begin
      failures++;
      $display("FAIL t6_quiet: issues=%0d valid=%0b, required 0 0", n_ldst - n0, Compute_valid);
    end
    push(1'b0, mk_ls(1'b1, 6'd30), 16'hbeef);
    tick();
    checks++;
    if (n_ldst != n0 + 1) begin
      failures++;
      $display("FAIL t6_resume: issues=%0d, required 1", n_ldst - n0);
    end
  endtask

  task automatic test_random();
    int k = 0;
    logic [ADDR_W-1:0] s1, s2, d;
    for (int i = 0; i < 400; i++) begin
      s1 = ADDR_W'($urandom_range(0, 7));
      s2 = ADDR_W'($urandom_range(0, 7));
      d  = ADDR_W'($urandom_range(0, 7));
      host_valid = ($urandom_range(0, 99) < 60);
      host_type  = ($urandom_range(0, 3) == 0);
      if (host_type) host_cmd = {1'($urandom), 3'($urandom), 3'($urandom), s1, s2, d};
      else           host_cmd = mk_ls(1'($urandom), s1);
      host_wdata    = ROW_NUM'($urandom);
      Compute_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    host_valid = 1'b0;
    Compute_ready = 1'b1;
    while ((model_q.size() != 0 || busy) && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (model_q.size() != 0 || busy !== 1'b0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL random_drain: pending=%0d busy=%0b reads=%0d, required 0 0 0", model_q.size(), busy, exp_rd.size());
    end
    Compute_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_clash_stall();
    test_no_clash();
    test_fifo_full();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
